// File: rtl/watermark_pkg.sv
`default_nettype none
// ============================================================================
//  Package : watermark_pkg
//  Shared widths and FSM state encodings for the block statistics stage.
//  Revision: 1.0 - initial release
// ============================================================================
package watermark_pkg;

  localparam int PIX_W   = 8;
  localparam int SIGMA_W = 7;
  localparam int VAR_W   = 14;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_ACC  = 2'd0;
  localparam logic [1:0] ST_VAR  = 2'd1;
  localparam logic [1:0] ST_SQRT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/isqrt_serial.sv
`default_nettype none
// ============================================================================
//  Module  : isqrt_serial
//  Restoring bit-serial integer square root, one result bit per clock,
//  MSB first. SIGMA_W cycles from start to the final result bit.
//  Revision: 1.0 - initial release
// ============================================================================
module isqrt_serial
  import watermark_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [VAR_W-1:0]   rad_i,
  output logic               done_o,
  output logic [SIGMA_W-1:0] root_o
);

  localparam logic [2:0] STEP_LAST = 3'(SIGMA_W - 1);

  logic [VAR_W-1:0]   rad_q;
  logic [SIGMA_W-1:0] root_q;
  logic [SIGMA_W+2:0] rem_q;
  logic [2:0]         step_q;
  logic               busy_q;

  logic [SIGMA_W+2:0] rem_shift;
  logic [SIGMA_W+2:0] trial;
  logic               fits;

  // Bring down the next radicand bit pair and test against 4*root+1.
  always_comb begin
    rem_shift = (SIGMA_W + 3)'({rem_q, rad_q[VAR_W-1 -: 2]});
    trial     = {1'b0, root_q, 2'b01};
    fits      = (rem_shift >= trial);
  end

  // One restoring step per cycle while busy; root holds once finished.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rad_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rad_q  <= rad_i;
      root_q <= '0;
      rem_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rad_q  <= rad_q << 2;
      rem_q  <= fits ? (rem_shift - trial) : rem_shift;
      root_q <= {root_q[SIGMA_W-2:0], fits};
      step_q <= step_q + 3'd1;
      if (step_q == STEP_LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done_o = busy_q && (step_q == STEP_LAST);
  assign root_o = root_q;

endmodule
`default_nettype wire

// File: rtl/block_stats.sv
`default_nettype none
// ============================================================================
//  Module  : block_stats
//  Streaming per-block mean and standard deviation, presented on a
//  valid/ready output in the alpha/beta stage input format.
//  Revision: 1.0 - initial release
// ============================================================================
module block_stats
  import watermark_pkg::*;
#(
  parameter int LOG_N   = 6,
  parameter int MU_SIZE = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [MU_SIZE-1:0] mu_k,
  output logic [SIGMA_W-1:0] sigma_k,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int SUM_W = LOG_N + PIX_W;
  localparam int SQ_W  = LOG_N + 2 * PIX_W;
  localparam int MU_SH = LOG_N - (MU_SIZE - 8);

  state_t             state_q, state_d;
  logic [LOG_N-1:0]   cnt_q;
  logic [SUM_W-1:0]   sum_q;
  logic [SQ_W-1:0]    sumsq_q;
  logic [MU_SIZE-1:0] mu_q;

  logic               accept;
  logic               sqrt_done;
  logic [PIX_W-1:0]   mean_i;
  logic [15:0]        mean_sq;
  logic [15:0]        sq_mean;
  logic [16:0]        var_diff;
  logic [VAR_W-1:0]   var_sat;

  assign pix_ready = rst && (state_q == ST_ACC);
  assign accept    = pix_valid && pix_ready;

  // Integer variance E[x^2] - floor(mean)^2, clamped at 0 and saturated to 14 bits.
  always_comb begin
    mean_i   = PIX_W'(sum_q >> LOG_N);
    sq_mean  = 16'(sumsq_q >> LOG_N);
    mean_sq  = {8'd0, mean_i} * {8'd0, mean_i};
    var_diff = {1'b0, sq_mean} - {1'b0, mean_sq};
    if (var_diff[16]) begin
      var_sat = '0;
    end else if (|var_diff[15:14]) begin
      var_sat = '1;
    end else begin
      var_sat = var_diff[13:0];
    end
  end

  // Next-state: accumulate, one variance cycle, serial sqrt, hold for handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:  if (accept && (cnt_q == '1)) state_d = ST_VAR;
      ST_VAR:  state_d = ST_SQRT;
      ST_SQRT: if (sqrt_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  // State, accumulators and latched mean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
      sum_q   <= '0;
      sumsq_q <= '0;
      mu_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sum_q   <= sum_q + SUM_W'(pix_in);
        sumsq_q <= sumsq_q + SQ_W'({8'd0, pix_in} * {8'd0, pix_in});
        cnt_q   <= cnt_q + 1'b1;
      end else if ((state_q == ST_DONE) && out_ready) begin
        sum_q   <= '0;
        sumsq_q <= '0;
      end
      if (state_q == ST_VAR) begin
        mu_q <= MU_SIZE'(sum_q >> MU_SH);
      end
    end
  end

  isqrt_serial u_isqrt (
    .clk     (clk),
    .rst     (rst),
    .start_i (state_q == ST_VAR),
    .rad_i   (var_sat),
    .done_o  (sqrt_done),
    .root_o  (sigma_k)
  );

  assign mu_k      = mu_q;
  assign out_valid = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_block_stats.sv
`default_nettype none
// ============================================================================
//  Module  : tb_block_stats
//  Scoreboard bench for block_stats: expected results are queued at stimulus
//  time and popped by a monitor on every output handshake.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_block_stats;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [9:0] mu_k;
  logic [6:0] sigma_k;
  logic       out_valid;
  logic       out_ready = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit prev_ov = 1'b0;
  bit rand_rdy = 1'b0;
  bit gaps = 1'b0;

  logic [16:0] exp_q[$];
  logic [7:0]  blk[64];

  block_stats #(.LOG_N(6), .MU_SIZE(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .mu_k      (mu_k),
    .sigma_k   (sigma_k),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency of every out_valid rise, scoreboard pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && !prev_ov) chk("latency", cyc - acc_cyc, 8);
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got mu_k=%0d sigma_k=%0d expected none", mu_k, sigma_k);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("mu_k", int'(mu_k), int'(e[16:7]));
          chk("sigma_k", int'(sigma_k), int'(e[6:0]));
        end
      end
    end else begin
      prev_ov = 1'b0;
    end
  end

  // Random downstream back-pressure when enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_pix(input logic [7:0] p);
    int w = 0;
    pix_in = p;
    pix_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (pix_ready) begin
        acc_cyc = cyc + 1;
        break;
      end
      w++;
      if (w > 300) begin
        chk("pix_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_block();
    for (int i = 0; i < 64; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 3));
      send_pix(blk[i]);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 1000) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    #1;
  endtask

  function automatic logic [16:0] model();
    int sum = 0;
    int sumsq = 0;
    int mean, v, s;
    for (int i = 0; i < 64; i++) begin
      sum += int'(blk[i]);
      sumsq += int'(blk[i]) * int'(blk[i]);
    end
    mean = sum / 64;
    v = sumsq / 64 - mean * mean;
    if (v < 0) v = 0;
    if (v > 16383) v = 16383;
    s = 0;
    while ((s + 1) * (s + 1) <= v) s++;
    return {10'(sum / 16), 7'(s)};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pix_ready"}, int'(pix_ready), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_mu_k"}, int'(mu_k), 0);
    chk({tag, "_sigma_k"}, int'(sigma_k), 0);
  endtask

  initial begin
    int w;
    // Reset state
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", int'(pix_ready), 1);

    // 1: flat block
    foreach (blk[i]) blk[i] = 8'd100;
    exp_q.push_back({10'd400, 7'd0});
    send_block();
    drain();

    // 2: half black, half 254
    foreach (blk[i]) blk[i] = (i < 32) ? 8'd0 : 8'd254;
    exp_q.push_back({10'd508, 7'd127});
    send_block();
    drain();

    // 3: alternating 10/20
    foreach (blk[i]) blk[i] = (i % 2 == 0) ? 8'd10 : 8'd20;
    exp_q.push_back({10'd60, 7'd5});
    send_block();
    drain();

    // 4: ramp 0..63
    foreach (blk[i]) blk[i] = 8'(i);
    exp_q.push_back({10'd126, 7'd19});
    send_block();
    drain();

    // 5: downstream stalls for 5 cycles in DONE
    out_ready = 1'b0;
    foreach (blk[i]) blk[i] = (i % 2 == 0) ? 8'd3 : 8'd5;
    exp_q.push_back({10'd16, 7'd1});
    send_block();
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!out_valid && w < 50);
    chk("stall_valid_seen", int'(out_valid), 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_mu_k", int'(mu_k), 16);
      chk("stall_sigma_k", int'(sigma_k), 1);
      chk("stall_pix_ready", int'(pix_ready), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("handshake_pix_ready", int'(pix_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_hs_out_valid", int'(out_valid), 0);
    chk("post_hs_pix_ready", int'(pix_ready), 1);
    @(posedge clk);
    #1;
    drain();

    // 6: reset after 30 pixels discards the partial block
    for (int i = 0; i < 30; i++) send_pix(8'd200);
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    foreach (blk[i]) blk[i] = 8'd50;
    exp_q.push_back({10'd200, 7'd0});
    send_block();
    drain();

    // 7: random blocks with input gaps and output back-pressure
    gaps = 1'b1;
    rand_rdy = 1'b1;
    for (int b = 0; b < 6; b++) begin
      foreach (blk[i]) blk[i] = 8'($urandom_range(0, 255));
      if (b == 1) foreach (blk[i]) blk[i] = 8'($urandom_range(120, 136));
      exp_q.push_back(model());
      send_block();
    end
    drain();
    rand_rdy = 1'b0;
    gaps = 1'b0;
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
